// File: rtl/uart_tx.sv
// uart_tx: UART transmitter sending start, 5..8 data bits LSB first, optional parity and stop, paced by tx_tick
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   tx_tick         one-clk pulse per bit period from the baud generator
//   i_num_bit_data  data length (00=5 .. 11=8 bits)
//   i_parity_en     append parity bit when 1
//   i_parity_type   0 = even, 1 = odd
//   i_data          character; bits above the selected length are ignored
//   i_tx_start      one-clk request, accepted only in IDLE
//   i_cts_n         clear-to-send, active-low; holds off the frame start
//   o_tx_serial     registered serial line, idle high
//   o_tx_done       one-clk pulse after the stop bit completes
module uart_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_tick,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  input  logic [7:0] i_data,
  input  logic       i_tx_start,
  input  logic       i_cts_n,
  output logic       o_tx_serial,
  output logic       o_tx_done
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] len_q, len_d;
  logic       pe_q, pe_d;
  logic       par_q, par_d;
  logic       ser_q, ser_d;
  logic       done_q, done_d;
  logic [7:0] data_m;
  // unused upper bits are cleared so they never reach the line or the parity
  assign data_m = i_data & (8'hFF >> (2'd3 - i_num_bit_data));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      pe_q    <= 1'b0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pe_q    <= pe_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pe_d    = pe_q;
    par_d   = par_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (i_tx_start) begin
        state_d = S_WAIT;
        sh_d    = data_m;
        len_d   = i_num_bit_data;
        pe_d    = i_parity_en;
        par_d   = ^data_m ^ i_parity_type;
      end
      S_WAIT: if (tx_tick && !i_cts_n) begin
        state_d = S_START;
        ser_d   = 1'b0;
      end
      S_START: if (tx_tick) begin
        state_d = S_DATA;
        ser_d   = sh_q[0];
        sh_d    = sh_q >> 1;
        cnt_d   = '0;
      end
      // cnt_q indexes the bit now on the line; the last one is 4 + len
      S_DATA: if (tx_tick) begin
        if (cnt_q == {1'b0, len_q} + 3'd4) begin
          state_d = pe_q ? S_PARITY : S_STOP;
          ser_d   = pe_q ? par_q : 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
          ser_d = sh_q[0];
          sh_d  = sh_q >> 1;
        end
      end
      S_PARITY: if (tx_tick) begin
        state_d = S_STOP;
        ser_d   = 1'b1;
      end
      S_STOP: if (tx_tick) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign o_tx_serial = ser_q;
  assign o_tx_done   = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed scoreboard bench for uart_tx
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_tick = 1'b0;
  logic [1:0] i_num_bit_data = 2'b11;
  logic       i_parity_en = 1'b0;
  logic       i_parity_type = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_tx_start = 1'b0;
  logic       i_cts_n = 1'b0;
  logic       o_tx_serial;
  logic       o_tx_done;
  int         total = 0;
  int         bad = 0;
  logic       sb[$];

  uart_tx dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_tick(tx_tick),
    .i_num_bit_data(i_num_bit_data),
    .i_parity_en(i_parity_en),
    .i_parity_type(i_parity_type),
    .i_data(i_data),
    .i_tx_start(i_tx_start),
    .i_cts_n(i_cts_n),
    .o_tx_serial(o_tx_serial),
    .o_tx_done(o_tx_done)
  );

  always #5 clk = ~clk;

  always begin
    repeat (3) @(posedge clk);
    #1 tx_tick = 1'b1;
    @(posedge clk);
    #1 tx_tick = 1'b0;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(posedge clk);
    while (tx_tick !== 1'b1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
  endtask

  task automatic request(input logic [7:0] d, input logic [1:0] nb, input logic pe, input logic pt);
    int ones;
    ones = 0;
    sb.push_back(1'b0);
    for (int i = 0; i < 5 + int'(nb); i++) begin
      sb.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) sb.push_back((ones % 2 == 1) ^ pt);
    sb.push_back(1'b1);
    i_data = d;
    i_num_bit_data = nb;
    i_parity_en = pe;
    i_parity_type = pt;
    i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    i_tx_start = 1'b0;
    i_data = ~d;
    i_num_bit_data = ~nb;
    i_parity_en = ~pe;
    i_parity_type = ~pt;
  endtask

  task automatic wait_start(input string tag, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      wait_tick();
      if (o_tx_serial === 1'b0) seen = 1'b1;
    end
    check({tag, "_start_seen"}, seen, 1'b1);
  endtask

  task automatic receive(input string tag);
    bit   seen;
    logic e;
    wait_start(tag, seen);
    if (!seen) begin
      sb.delete();
      return;
    end
    e = sb.pop_front();
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      check({tag, "_bit"}, o_tx_serial, e);
      check({tag, "_no_early_done"}, o_tx_done, 1'b0);
    end
    wait_tick();
    check({tag, "_done_pulse"}, o_tx_done, 1'b1);
    check({tag, "_idle_line"}, o_tx_serial, 1'b1);
    @(posedge clk);
    #2;
    check({tag, "_done_one_clk"}, o_tx_done, 1'b0);
  endtask

  initial begin
    bit seen;
    bit went_low;
    bit done_seen;
    repeat (3) @(posedge clk);
    #2;
    check("reset_line", o_tx_serial, 1'b1);
    check("reset_done", o_tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("post_reset_line", o_tx_serial, 1'b1);

    request(8'h55, 2'b11, 1'b0, 1'b0);
    receive("8n1_55");
    request(8'hFF, 2'b00, 1'b0, 1'b0);
    receive("5n1_ff");
    request(8'hAA, 2'b11, 1'b1, 1'b0);
    receive("8e1_aa");
    request(8'hAA, 2'b11, 1'b1, 1'b1);
    receive("8o1_aa");
    request(8'h81, 2'b10, 1'b1, 1'b0);
    receive("7e1_81");
    request(8'h7F, 2'b01, 1'b1, 1'b1);
    receive("6o1_7f");

    i_cts_n = 1'b1;
    request(8'h99, 2'b11, 1'b0, 1'b0);
    went_low = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #2;
      if (o_tx_serial !== 1'b1) went_low = 1'b1;
      if (o_tx_done !== 1'b0) done_seen = 1'b1;
    end
    check("cts_hold_line", went_low, 1'b0);
    check("cts_hold_done", done_seen, 1'b0);
    i_cts_n = 1'b0;
    receive("cts_99");

    request(8'h00, 2'b11, 1'b0, 1'b0);
    wait_start("rst_mid", seen);
    repeat (3) wait_tick();
    check("rst_mid_data_low", o_tx_serial, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_line", o_tx_serial, 1'b1);
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      if (o_tx_done !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (o_tx_done !== 1'b0) done_seen = 1'b1;
      if (o_tx_serial !== 1'b1) went_low = 1'b1;
    end
    check("rst_mid_no_done", done_seen, 1'b0);
    check("rst_mid_dropped", went_low, 1'b0);
    request(8'h3C, 2'b11, 1'b0, 1'b0);
    receive("after_rst_3c");
    request(8'hC3, 2'b11, 1'b1, 1'b0);
    receive("back_to_back_c3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
